// File: rtl/button_bank_pkg.sv
// Purpose: shared FSM state type, its encodings and a counter-range helper for button_bank.
// Latency: n/a, holds types and functions only.
// Backpressure: none.
package button_bank_pkg;

  localparam logic [1:0] ENC_IDLE  = 2'b00;
  localparam logic [1:0] ENC_PRESS = 2'b01;
  localparam logic [1:0] ENC_HELD  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = ENC_IDLE,
    PRESS = ENC_PRESS,
    HELD  = ENC_HELD
  } btn_state_t;

  // A count is usable when it is at least 1 and representable in a w-bit counter.
  function automatic bit cnt_ok(input longint c, input int w);
    if (c < 1) return 1'b0;
    if (w >= 63) return 1'b1;
    return c < (longint'(1) << w);
  endfunction

endpackage

// File: rtl/button_chan.sv
// Purpose: one debounced button channel: sync, hysteresis debounce, edges, toggles, press classification.
// Latency: switch->level 2+ON/OFF cycles; edge, short_release, long_press pulses one cycle after level moves.
// Backpressure: none; free-running. Optional auto-repeat when BUTTON_BANK_REPEAT_EN is defined.
module button_chan
  import button_bank_pkg::*;
#(
  parameter int CNT_W                  = 32,
  parameter int TURN_ON_CLOCK_COUNT    = 60000,
  parameter int TURN_OFF_CLOCK_COUNT   = 35000,
  parameter int LONG_PRESS_CLOCK_COUNT = 50000000,
  parameter int REPEAT_CLOCK_COUNT     = 10000000
) (
  input  logic clk,
  input  logic reset_b,
  input  logic switch,
  input  logic clr_toggle,
  output logic level,
  output logic positive_edge,
  output logic negative_edge,
  output logic positive_toggled,
  output logic negative_toggled,
  output logic long_press,
  output logic short_release,
  output logic repeat_pulse
);

  if (!cnt_ok(longint'(TURN_ON_CLOCK_COUNT), CNT_W) ||
      !cnt_ok(longint'(TURN_OFF_CLOCK_COUNT), CNT_W) ||
      !cnt_ok(longint'(LONG_PRESS_CLOCK_COUNT), CNT_W) ||
      !cnt_ok(longint'(REPEAT_CLOCK_COUNT), CNT_W)) begin : g_bad_count
    $error("button_chan: every *_CLOCK_COUNT must be >= 1 and fit in CNT_W bits");
  end

  logic             sync_q1;
  logic             sync_q2;
  logic             level_d;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] db_limit;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_inc;
  logic             rise_now;
  logic             fall_now;
  btn_state_t       state;

  // Debounce threshold depends on which way the level would move; hold counter saturates.
  always_comb begin
    db_limit = level ? CNT_W'(TURN_OFF_CLOCK_COUNT - 1) : CNT_W'(TURN_ON_CLOCK_COUNT - 1);
    hold_inc = (hold_cnt == '1) ? hold_cnt : hold_cnt + CNT_W'(1);
    rise_now = level & ~level_d;
    fall_now = ~level & level_d;
  end

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= switch;
      sync_q2 <= sync_q1;
    end
  end

  // Hysteresis debounce: level flips only after the synced input disagrees for a full count.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else if (sync_q2 != level) begin
      if (db_cnt == db_limit) begin
        level  <= ~level;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Registered edge pulses, one cycle after the level moves.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      level_d       <= 1'b0;
      positive_edge <= 1'b0;
      negative_edge <= 1'b0;
    end else begin
      level_d       <= level;
      positive_edge <= rise_now;
      negative_edge <= fall_now;
    end
  end

  // Toggle flops; a clear beats a coincident edge.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      positive_toggled <= 1'b0;
      negative_toggled <= 1'b0;
    end else if (clr_toggle) begin
      positive_toggled <= 1'b0;
      negative_toggled <= 1'b0;
    end else begin
      if (positive_edge) positive_toggled <= ~positive_toggled;
      if (negative_edge) negative_toggled <= ~negative_toggled;
    end
  end

`ifdef BUTTON_BANK_REPEAT_EN
  logic [CNT_W-1:0] rpt_cnt;
  logic [CNT_W-1:0] rpt_inc;

  // Saturating increment for the repeat period counter.
  always_comb rpt_inc = (rpt_cnt == '1) ? rpt_cnt : rpt_cnt + CNT_W'(1);
`else
  assign repeat_pulse = 1'b0;
`endif

  // Press classifier: transitions use the same condition that fires the edge pulses, so
  // short_release and long_press land on the same cycle as the corresponding edge timing.
  // hold_cnt counts cycles the level has been high, including the rise cycle.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      long_press    <= 1'b0;
      short_release <= 1'b0;
`ifdef BUTTON_BANK_REPEAT_EN
      rpt_cnt       <= '0;
      repeat_pulse  <= 1'b0;
`endif
    end else begin
      long_press    <= 1'b0;
      short_release <= 1'b0;
`ifdef BUTTON_BANK_REPEAT_EN
      repeat_pulse  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rise_now) begin
            hold_cnt <= CNT_W'(1);
            if (LONG_PRESS_CLOCK_COUNT == 1) begin
              state      <= HELD;
              long_press <= 1'b1;
`ifdef BUTTON_BANK_REPEAT_EN
              rpt_cnt    <= '0;
`endif
            end else begin
              state <= PRESS;
            end
          end
        end
        PRESS: begin
          if (fall_now) begin
            state         <= IDLE;
            short_release <= 1'b1;
            hold_cnt      <= '0;
          end else if (hold_cnt == CNT_W'(LONG_PRESS_CLOCK_COUNT - 1)) begin
            state      <= HELD;
            long_press <= 1'b1;
            hold_cnt   <= hold_inc;
`ifdef BUTTON_BANK_REPEAT_EN
            rpt_cnt    <= '0;
`endif
          end else begin
            hold_cnt <= hold_inc;
          end
        end
        HELD: begin
          if (fall_now) begin
            state    <= IDLE;
            hold_cnt <= '0;
`ifdef BUTTON_BANK_REPEAT_EN
            rpt_cnt  <= '0;
`endif
          end else begin
            hold_cnt <= hold_inc;
`ifdef BUTTON_BANK_REPEAT_EN
            if (rpt_cnt == CNT_W'(REPEAT_CLOCK_COUNT - 1)) begin
              repeat_pulse <= 1'b1;
              rpt_cnt      <= '0;
            end else begin
              rpt_cnt <= rpt_inc;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/button_bank.sv
// Purpose: NUM_CH independent debounced push-button channels for UI control logic.
// Latency: switch->level 2+ON/OFF cycles; pulses one cycle later. Auto-repeat needs BUTTON_BANK_REPEAT_EN.
// Backpressure: none; every channel is free-running and independent.
module button_bank
  import button_bank_pkg::*;
#(
  parameter int NUM_CH                 = 4,
  parameter int CNT_W                  = 32,
  parameter int TURN_ON_CLOCK_COUNT    = 60000,
  parameter int TURN_OFF_CLOCK_COUNT   = 35000,
  parameter int LONG_PRESS_CLOCK_COUNT = 50000000,
  parameter int REPEAT_CLOCK_COUNT     = 10000000
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic [NUM_CH-1:0] switch,
  input  logic [NUM_CH-1:0] clr_toggle,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] positive_edge,
  output logic [NUM_CH-1:0] negative_edge,
  output logic [NUM_CH-1:0] positive_toggled,
  output logic [NUM_CH-1:0] negative_toggled,
  output logic [NUM_CH-1:0] long_press,
  output logic [NUM_CH-1:0] short_release,
  output logic [NUM_CH-1:0] repeat_pulse
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    button_chan #(
      .CNT_W                 (CNT_W),
      .TURN_ON_CLOCK_COUNT   (TURN_ON_CLOCK_COUNT),
      .TURN_OFF_CLOCK_COUNT  (TURN_OFF_CLOCK_COUNT),
      .LONG_PRESS_CLOCK_COUNT(LONG_PRESS_CLOCK_COUNT),
      .REPEAT_CLOCK_COUNT    (REPEAT_CLOCK_COUNT)
    ) u_chan (
      .clk             (clk),
      .reset_b         (reset_b),
      .switch          (switch[i]),
      .clr_toggle      (clr_toggle[i]),
      .level           (level[i]),
      .positive_edge   (positive_edge[i]),
      .negative_edge   (negative_edge[i]),
      .positive_toggled(positive_toggled[i]),
      .negative_toggled(negative_toggled[i]),
      .long_press      (long_press[i]),
      .short_release   (short_release[i]),
      .repeat_pulse    (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_bank.sv
// Purpose: scoreboard bench for button_bank with NUM_CH=2, ON=4, OFF=3, LONG=20, REPEAT=5.
// Latency: expected pulse cycles are hand-derived from switch/reset timing.
// Backpressure: none; repeat expectations follow BUTTON_BANK_REPEAT_EN.
module tb_button_bank;

  localparam int NC = 2;

  logic          clk = 1'b0;
  logic          reset_b;
  logic [NC-1:0] switch;
  logic [NC-1:0] clr_toggle;
  logic [NC-1:0] level, positive_edge, negative_edge, positive_toggled, negative_toggled;
  logic [NC-1:0] long_press, short_release, repeat_pulse;

  button_bank #(
    .NUM_CH(NC), .CNT_W(16), .TURN_ON_CLOCK_COUNT(4), .TURN_OFF_CLOCK_COUNT(3),
    .LONG_PRESS_CLOCK_COUNT(20), .REPEAT_CLOCK_COUNT(5)
  ) dut (
    .clk(clk), .reset_b(reset_b), .switch(switch), .clr_toggle(clr_toggle),
    .level(level), .positive_edge(positive_edge), .negative_edge(negative_edge),
    .positive_toggled(positive_toggled), .negative_toggled(negative_toggled),
    .long_press(long_press), .short_release(short_release), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  // Cycle index: number of rising edges so far, read on falling edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 pos_edge, 1 neg_edge, 2 long_press, 3 short_release, 4 repeat_pulse
  typedef struct packed { int cyc; int ch; int kind; } ev_t;
  ev_t   exp_q[$];
  int    passed = 0;
  int    total  = 0;
  string kname[5] = '{"pos_edge", "neg_edge", "long_press", "short_release", "repeat_pulse"};

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic void expect_ev(input int c, input int ch, input int k);
    ev_t e;
    e.cyc = c; e.ch = ch; e.kind = k;
    exp_q.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " level"},            int'(level), 0);
    check({tag, " positive_edge"},    int'(positive_edge), 0);
    check({tag, " negative_edge"},    int'(negative_edge), 0);
    check({tag, " positive_toggled"}, int'(positive_toggled), 0);
    check({tag, " negative_toggled"}, int'(negative_toggled), 0);
    check({tag, " long_press"},       int'(long_press), 0);
    check({tag, " short_release"},    int'(short_release), 0);
    check({tag, " repeat_pulse"},     int'(repeat_pulse), 0);
  endtask

  // Monitor: every pulse the DUT presents must match the head of the expectation queue.
  always @(negedge clk) begin : monitor
    logic [4:0] p;
    ev_t        got;
    ev_t        want;
    for (int ch = 0; ch < NC; ch++) begin
      p = {repeat_pulse[ch], short_release[ch], long_press[ch], negative_edge[ch], positive_edge[ch]};
      for (int k = 0; k < 5; k++) begin
        if (p[k]) begin
          got.cyc = cyc; got.ch = ch; got.kind = k;
          total++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected %s: ch%0d at cycle %0d, nothing required", kname[k], ch, cyc);
          end else begin
            want = exp_q.pop_front();
            if (got == want) passed++;
            else $display("FAIL pulse: got %s ch%0d at cycle %0d, required %s ch%0d at cycle %0d",
                          kname[k], ch, cyc, kname[want.kind], want.ch, want.cyc);
          end
        end
      end
    end
  end

  initial begin
    int r, c, d, e;
    bit pat[4];
    pat = '{1'b1, 1'b1, 1'b1, 1'b0};
    reset_b = 1'b0; switch = 2'b11; clr_toggle = 2'b00;

    // 1: reset with both buttons down, then release reset
    tick(3);
    check_all_zero("reset");
    r = cyc;
    reset_b = 1'b1;
    expect_ev(r + 7, 0, 0); expect_ev(r + 7, 1, 0);
    tick(5);  check("t1 level before rise", int'(level), 0);
    tick(1);  check("t1 level rise", int'(level), 3);
    tick(4);  switch = 2'b00;                      // cycle r+10
    expect_ev(r + 16, 0, 1); expect_ev(r + 16, 0, 3);
    expect_ev(r + 16, 1, 1); expect_ev(r + 16, 1, 3);
    tick(10);
    check("t1 positive_toggled", int'(positive_toggled), 3);
    check("t1 negative_toggled", int'(negative_toggled), 3);
    clr_toggle = 2'b11; tick(1); clr_toggle = 2'b00; tick(1);
    check("t1 toggles cleared", int'({positive_toggled, negative_toggled}), 0);

    // 2: bouncy press on ch0
    tick(5);
    for (int i = 0; i < 4; i++) begin switch[0] = pat[i]; tick(1); end
    c = cyc; switch[0] = 1'b1;
    expect_ev(c + 7, 0, 0);
    tick(5);  check("t2 level before rise", int'(level), 0);
    tick(1);  check("t2 level rise", int'(level), 1);

    // 3: short hold then release
    tick(4);  switch[0] = 1'b0;                    // cycle c+10
    expect_ev(c + 16, 0, 1); expect_ev(c + 16, 0, 3);
    tick(12);
    check("t2 positive_toggled", int'(positive_toggled), 1);
    check("t3 negative_toggled", int'(negative_toggled), 1);

    // 4: long hold on ch0
    tick(5);
    d = cyc; switch[0] = 1'b1;
    expect_ev(d + 7, 0, 0); expect_ev(d + 26, 0, 2);
`ifdef BUTTON_BANK_REPEAT_EN
    expect_ev(d + 31, 0, 4); expect_ev(d + 36, 0, 4); expect_ev(d + 41, 0, 4);
`endif
    tick(40); switch[0] = 1'b0;                    // cycle d+40
    expect_ev(d + 46, 0, 1);
    tick(4);  check("t4 level still high", int'(level), 1);
    tick(1);  check("t4 level fall", int'(level), 0);
    tick(15);
    check("t4 toggles", int'({positive_toggled, negative_toggled}), 0);

    // 5: clear coincident with positive edge on ch0, ch1 toggles normally
    e = cyc; switch = 2'b11;
    expect_ev(e + 7, 0, 0); expect_ev(e + 7, 1, 0);
    expect_ev(e + 26, 0, 2); expect_ev(e + 26, 1, 2);
    tick(7);  clr_toggle = 2'b01;                  // high while positive_edge is high
    tick(1);  clr_toggle = 2'b00;
    tick(1);  check("t5 positive_toggled clr wins", int'(positive_toggled), 2);

    // 6: reset mid-hold while both channels are HELD
    tick(19); reset_b = 1'b0;                      // cycle e+28
    tick(1);  check_all_zero("midreset");
    switch = 2'b00;
    tick(1);  reset_b = 1'b1;
    tick(30);
    check("t6 level after reset", int'(level), 0);
    check("scoreboard drained", exp_q.size(), 0);
    foreach (exp_q[i])
      $display("outstanding: %s ch%0d at cycle %0d", kname[exp_q[i].kind], exp_q[i].ch, exp_q[i].cyc);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
